aes_dec_round_ctrl: RTL
=======================

# aes_dec_round_ctrl

Round sequencer for the AES-128 inverse cipher datapath. It accepts a ciphertext block over a valid/ready handshake and walks the 11 AddRoundKey steps: round-key index 10 down to 0. For each step it drives the key-addition `count`/`enable`, the InvShiftRows/InvSubBytes/InvMixColumns enables, and the state-register controls. It sits between the key-expansion block, which supplies the 1408-bit round-key bus and `keys_valid`, and the decryption datapath.

## Interface
- `NUM_ROUNDS`, default 10: AES rounds; the key-index width stays 4 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `keys_valid` input 1: the round-key bus is complete and stable.
- `in_valid` input 1: ciphertext block is present on the datapath input.
- `in_ready` output 1: the controller can accept a block.
- `out_valid` output 1: plaintext is present in the state register.
- `out_ready` input 1: the consumer takes the plaintext.
- `busy` output 1: a block is in flight (LOAD, ROUND, FINAL).
- `key_lock` output 1: key expansion must not change the round keys; equals `busy | out_valid`.
- `count` output 4: round-key index to the key-addition stage.
- `key_add_en` output 1: enable for the key-addition XOR.
- `inv_rows_en` output 1: enable for InvShiftRows and InvSubBytes; bypass when 0.
- `inv_mix_en` output 1: enable for InvMixColumns; bypass when 0.
- `sel_input` output 1: 1 = the datapath input mux takes the external block; 0 = it takes the state register.
- `state_we` output 1: write enable for the 128-bit state register.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- Internal 4-bit round counter `rnd`.
- Outputs are decoded from state and `rnd`.
- **IDLE**
  - `in_ready = keys_valid`.
  - On `in_valid & in_ready`: go to LOAD and set `rnd <= NUM_ROUNDS`.
- **LOAD** (first AddRoundKey only)
  - `sel_input=1`, `key_add_en=1`, `count=rnd` (=10), `state_we=1`.
  - Transformation enables are 0.
  - Next: ROUND, `rnd <= rnd-1`.
- **ROUND** (rounds 1..9)
  - `sel_input=0`, `inv_rows_en=1`, `key_add_en=1`, `inv_mix_en=1`, `count=rnd`, `state_we=1`.
  - Datapath order: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - While `rnd != 1`: stay in ROUND, `rnd <= rnd-1`.
  - When `rnd == 1`: go to FINAL, `rnd <= 0`.
- **FINAL**
  - Same as ROUND except `inv_mix_en=0`; `count=0`.
  - Next: DONE.
- **DONE**
  - `out_valid=1`, `state_we=0`.
  - The state register holds its value until `out_ready`.
  - On `out_ready`: go to IDLE. No new block is accepted in the same cycle; `in_ready` is 0 in DONE.
- Every enable and `state_we` is 0 outside LOAD, ROUND and FINAL.
- `count` = 0 in IDLE and DONE.
- `count` never exceeds 10. Values 11–15 are never driven; any `rnd` > 10 forces IDLE on the next edge.
- `keys_valid` is sampled only at acceptance. A drop while `key_lock=1` is ignored; the key producer must honour `key_lock`.
- `in_valid` is ignored outside IDLE.

## Timing
- Reset values (synchronous):
  - state IDLE, `rnd=0`;
  - `in_ready=0` until the first edge after reset release, then `keys_valid`;
  - `out_valid=0`, `busy=0`, `key_lock=0`, `count=0`, all enables 0, `sel_input=0`, `state_we=0`.
- Accept at edge T. LOAD occupies cycle T+1, ROUND cycles T+2..T+10, FINAL cycle T+11.
- `out_valid` rises in cycle T+12. Latency is 12 cycles from accept to `out_valid`, plus consumer stall.
- Throughput: one block per 13 cycles with `out_ready` held at 1.
- `rst` asserted in any state: the next edge returns to IDLE with reset values. The partial state register is abandoned and `out_valid` is never raised for that block.
- `rst` and `in_valid` high in the same cycle: reset wins and the block is not accepted.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `keys_valid=0`, `in_valid=1` → `in_ready=0`, `count=0`, no state change for 20 cycles.
- FIPS-197 C.1 vector: keys 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → `count` sequence 10,9,…,0 on cycles T+1..T+11; `inv_mix_en`=1 exactly on cycles T+2..T+10; `out_valid` at T+12 with plaintext 00112233445566778899aabbccddeeff.
- Backpressure: `out_ready=0` for 5 cycles after `out_valid` → `out_valid` and the plaintext held stable, `in_ready=0`, `key_lock=1`; after `out_ready` is pulsed, IDLE on the next cycle.
- Back-to-back blocks with `out_ready=1` and `in_valid=1` continuously → second accept exactly 13 cycles after the first; both plaintexts correct.
- Reset mid-operation: assert `rst` when `count=5` → next cycle `busy=0`, `count=0`, `out_valid` never rises; a following block decrypts correctly.
- Key hold: drop `keys_valid` at `count=7` → sequence completes unchanged with correct plaintext; no new accept until `keys_valid` is 1 again.

Source files
------------

// File: rtl/aes_dec_round_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_dec_round_ctrl_if
//  Description : Handshake and datapath-control bundle for the AES-128
//                inverse-cipher round sequencer.
//                slave  : the sequencer's view (drives handshake outputs
//                         and all datapath controls).
//                master : the surrounding system's view (key expander,
//                         block producer, plaintext consumer).
//  Signals     : keys_valid, in_valid, out_ready          (master -> slave)
//                in_ready, out_valid, busy, key_lock,
//                count[3:0], key_add_en, inv_rows_en,
//                inv_mix_en, sel_input, state_we          (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_dec_round_ctrl_if;
    logic       keys_valid;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       key_lock;
    logic [3:0] count;
    logic       key_add_en;
    logic       inv_rows_en;
    logic       inv_mix_en;
    logic       sel_input;
    logic       state_we;

    modport slave (
        input  keys_valid, in_valid, out_ready,
        output in_ready, out_valid, busy, key_lock, count,
               key_add_en, inv_rows_en, inv_mix_en, sel_input, state_we
    );

    modport master (
        output keys_valid, in_valid, out_ready,
        input  in_ready, out_valid, busy, key_lock, count,
               key_add_en, inv_rows_en, inv_mix_en, sel_input, state_we
    );
endinterface
`default_nettype wire

// File: rtl/aes_dec_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_dec_round_ctrl
//  Description : Round sequencer for the AES-128 inverse cipher. Accepts a
//                ciphertext block on a valid/ready handshake, then steps the
//                round-key index from NUM_ROUNDS down to 0: one plain
//                AddRoundKey (LOAD), NUM_ROUNDS-1 full inverse rounds
//                (ROUND), one round without InvMixColumns (FINAL), and holds
//                the plaintext (DONE) until the consumer takes it.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - aes_dec_round_ctrl_if.slave (handshake + controls)
//  Revision    : 1.0  initial release
// ============================================================================
module aes_dec_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    aes_dec_round_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] C_LAST_KEY = 4'(NUM_ROUNDS);

    logic [2:0] r_state;
    logic [3:0] r_rnd;
    // Cleared by reset, set on the first edge after release: keeps in_ready
    // low for the first post-reset cycle.
    logic       r_armed;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_rnd_bad;
    logic       w_active;

    always_comb begin
        w_rnd_bad  = (r_rnd > C_LAST_KEY);
        w_active   = (r_state == S_LOAD) || (r_state == S_ROUND) ||
                     (r_state == S_FINAL);
        // Gating with rst makes "reset wins" visible on the handshake too.
        w_in_ready = (r_state == S_IDLE) && r_armed && !rst && bus.keys_valid;
        w_accept   = w_in_ready && bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rnd   <= 4'd0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_rnd_bad) begin
                // Out-of-range key index: abandon the block.
                r_state <= S_IDLE;
                r_rnd   <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_state <= S_LOAD;
                            r_rnd   <= C_LAST_KEY;
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_ROUND;
                        r_rnd   <= r_rnd - 4'd1;
                    end
                    S_ROUND: begin
                        if (r_rnd == 4'd1) begin
                            r_state <= S_FINAL;
                            r_rnd   <= 4'd0;
                        end else begin
                            r_rnd   <= r_rnd - 4'd1;
                        end
                    end
                    S_FINAL: begin
                        r_state <= S_DONE;
                    end
                    S_DONE: begin
                        if (bus.out_ready) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_rnd   <= 4'd0;
                    end
                endcase
            end
        end
    end

    // All controls are a pure decode of state and round counter.
    always_comb begin
        bus.in_ready    = w_in_ready;
        bus.out_valid   = (r_state == S_DONE);
        bus.busy        = w_active;
        bus.key_lock    = w_active || (r_state == S_DONE);
        bus.count       = (w_active && !w_rnd_bad) ? r_rnd : 4'd0;
        bus.key_add_en  = w_active;
        bus.state_we    = w_active;
        bus.sel_input   = (r_state == S_LOAD);
        bus.inv_rows_en = (r_state == S_ROUND) || (r_state == S_FINAL);
        bus.inv_mix_en  = (r_state == S_ROUND);
    end

endmodule
`default_nettype wire
